// File: rtl/sig_pkg.sv
// sig_pkg: shared types and defaults for the triggered snapshot engine.
package sig_pkg;
    localparam int ADDR_WIDTH_DEF = 9;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRE_TRIG_DEF   = 128;
    typedef enum logic [1:0] {FILL, POST, READOUT} state_t;
    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/dpram.sv
// dpram: simple dual-port RAM, one write port and one registered read port.
module dpram
    import sig_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  wen_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  ren_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem [depth(ADDR_WIDTH)];
    logic [DATA_WIDTH-1:0] rdata_q;
    always_ff @(posedge clk) begin
        if (wen_i) mem[waddr_i] <= wdata_i;
        if (ren_i) rdata_q <= mem[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/sig_snapshot.sv
// sig_snapshot: circular capture buffer that freezes a DEPTH-sample window around
// a trigger and streams it out oldest-first over valid/ready.
module sig_snapshot
    import sig_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRE_TRIG   = PRE_TRIG_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] microphone,
    input  logic                  trigger,
    output logic                  armed,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);
    localparam int DEPTH = depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] PRE_W     = ADDR_WIDTH'(PRE_TRIG);
    localparam logic [ADDR_WIDTH-1:0] POST_INIT = ADDR_WIDTH'(DEPTH - PRE_TRIG - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_END   = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d, post_cnt_q, post_cnt_d;
    logic [ADDR_WIDTH:0]   rd_cnt_q, rd_cnt_d;
    logic                  armed_q, armed_d;
    logic                  ram_vld_q, ram_vld_d, ram_last_q, ram_last_d;
    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                  skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic [DATA_WIDTH-1:0] ram_data;
    logic [2:0]            occ;
    logic                  wen, pop, take, issue;

    assign wen  = en && state_q != READOUT;
    assign pop  = out_valid_q && out_ready;
    assign take = pop || !out_valid_q;
    // Words held after this edge; a read issued now lands next cycle and needs a free slot.
    assign occ   = {2'b0, out_valid_q} + {2'b0, skid_valid_q} + {2'b0, ram_vld_q} - {2'b0, pop};
    assign issue = state_q == READOUT && rd_cnt_q < CNT_END && occ < 3'd2;

    dpram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
        .clk     (clk),
        .wen_i   (wen),
        .waddr_i (wr_ptr_q),
        .wdata_i (microphone),
        .ren_i   (1'b1),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_data)
    );

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wen ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_cnt_d   = issue ? rd_cnt_q + 1'b1 : rd_cnt_q;
        fill_cnt_d = fill_cnt_q;
        post_cnt_d = post_cnt_q;
        ram_vld_d  = issue;
        ram_last_d = rd_cnt_q == CNT_END - 1'b1;
        if (state_q == FILL && en) begin
            fill_cnt_d = fill_cnt_q == PRE_W ? fill_cnt_q : fill_cnt_q + 1'b1;
            if (armed_q && trigger) begin
                state_d    = POST_INIT == '0 ? READOUT : POST;
                post_cnt_d = POST_INIT;
                rd_ptr_d   = wr_ptr_q - PRE_W;
                rd_cnt_d   = '0;
            end
        end
        if (state_q == POST && en) begin
            post_cnt_d = post_cnt_q - 1'b1;
            state_d    = post_cnt_q == 1 ? READOUT : POST;
        end
        if (state_q == READOUT && pop && out_last_q) begin
            state_d    = FILL;
            fill_cnt_d = '0;
        end
        armed_d      = state_d == FILL && fill_cnt_d == PRE_W;
        out_valid_d  = take ? skid_valid_q || ram_vld_q : out_valid_q;
        out_data_d   = take ? (skid_valid_q ? skid_data_q : ram_data) : out_data_q;
        out_last_d   = take ? (skid_valid_q ? skid_last_q : ram_last_q) : out_last_q;
        skid_valid_d = take ? skid_valid_q && ram_vld_q : skid_valid_q || ram_vld_q;
        skid_data_d  = ram_vld_q ? ram_data : skid_data_q;
        skid_last_d  = ram_vld_q ? ram_last_q : skid_last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_cnt_q     <= '0;
            fill_cnt_q   <= '0;
            post_cnt_q   <= '0;
            armed_q      <= 1'b0;
            ram_vld_q    <= 1'b0;
            ram_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_cnt_q     <= rd_cnt_d;
            fill_cnt_q   <= fill_cnt_d;
            post_cnt_q   <= post_cnt_d;
            armed_q      <= armed_d;
            ram_vld_q    <= ram_vld_d;
            ram_last_q   <= ram_last_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
        end
    end

    assign armed     = armed_q;
    assign busy      = state_q != FILL;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
endmodule

// File: tb/tb_sig_snapshot.sv
// tb_sig_snapshot: vector table, directed corner sequences and random traffic
// checked against a sample-history model of the capture window.
module tb_sig_snapshot;
    localparam int AW = 4, DW = 8, PRE = 4, DEPTH = 16;

    logic          clk = 1'b0, rst, en, trigger, out_ready;
    logic [DW-1:0] mic, out_data;
    logic          armed, busy, out_valid, out_last;

    always #5 clk = ~clk;

    sig_snapshot #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRE_TRIG(PRE)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .microphone (mic),
        .trigger    (trigger),
        .armed      (armed),
        .busy       (busy),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    typedef struct {logic en; logic trig; logic armed; logic busy;} vec_t;
    vec_t tab[8];

    int tests = 0, fails = 0;
    int m_state, m_fill, m_post, m_ro, m_words;
    logic [DW-1:0] ramp, prev_data;
    logic [DW-1:0] hist[$], exp_q[$], got[$];
    logic prev_stall, prev_acc, prev_last;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_fill = 0; m_post = 0; m_ro = 0; m_words = 0; ramp = '0;
        hist.delete(); exp_q.delete();
        prev_stall = 1'b0; prev_acc = 1'b0; prev_data = '0; prev_last = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; trigger = 1'b0; out_ready = 1'b0; mic = '0;
        @(negedge clk);
        model_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_armed", armed, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
    endtask

    // Called at a falling edge: check outputs, drive one cycle of inputs, advance the model.
    task automatic tick(input logic e, input logic t, input logic r);
        logic acc;
        chk("armed", armed, int'(m_state == 0 && m_fill >= PRE));
        chk("busy", busy, int'(m_state != 0));
        if (m_state != 2 || m_ro < 2) chk("valid_idle", out_valid, 0);
        if (m_state == 2 && m_ro == 2) chk("first_valid", out_valid, 1);
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
            chk("stall_last", out_last, prev_last);
        end
        if (prev_acc && m_state == 2) chk("no_bubble", out_valid, 1);
        en = e; trigger = t; out_ready = r;
        mic = (m_state == 2) ? DW'($urandom) : ramp;
        acc = out_valid && r;
        prev_stall = out_valid && !r; prev_data = out_data; prev_last = out_last; prev_acc = acc;
        if (acc && exp_q.size() > 0) begin
            chk("data", out_data, exp_q[0]);
            void'(exp_q.pop_front());
            got.push_back(out_data);
            m_words++;
            chk("last", out_last, int'(m_words == DEPTH));
        end
        case (m_state)
            0: if (e) begin
                hist.push_back(ramp);
                if (hist.size() > 32) void'(hist.pop_front());
                ramp++;
                if (m_fill >= PRE && t) begin
                    exp_q.delete();
                    for (int i = PRE; i >= 0; i--) exp_q.push_back(hist[hist.size() - 1 - i]);
                    m_state = 1; m_post = DEPTH - PRE - 1; m_words = 0;
                end else if (m_fill < PRE) m_fill++;
            end
            1: if (e) begin
                exp_q.push_back(ramp);
                ramp++;
                m_post--;
                if (m_post == 0) begin m_state = 2; m_ro = 0; end
            end
            default: begin
                m_ro++;
                if (m_words == DEPTH) begin m_state = 0; m_fill = 0; end
                if (m_ro > 400) begin
                    chk("readout_timeout", m_ro, 0);
                    m_state = 0; m_fill = 0;
                end
            end
        endcase
        @(negedge clk);
    endtask

    // mode 0: ready always; 1: random ready and trigger; 2: strict 1,0 toggle then random ready
    task automatic drain(input int mode);
        int n = 0;
        while (m_state != 0 && n < 600) begin
            tick(1'b1, mode == 1 ? 1'($urandom % 2) : 1'b0,
                 mode == 0 ? 1'b1 : (mode == 2 && m_words < 6) ? 1'(n % 2 == 0) : 1'($urandom % 3 != 0));
            n++;
        end
        chk("drain_done", m_state, 0);
    endtask

    task automatic chk_window(input string name, input int first, input int at4, input int last);
        chk({name, "_size"}, got.size(), DEPTH);
        if (got.size() == DEPTH) begin
            chk({name, "_w0"}, got[0], first);
            chk({name, "_w4"}, got[4], at4);
            chk({name, "_w15"}, got[15], last);
        end
    endtask

    initial begin
        tab[0] = '{1'b1, 1'b1, 1'b0, 1'b0};
        tab[1] = '{1'b1, 1'b1, 1'b0, 1'b0};
        tab[2] = '{1'b1, 1'b1, 1'b0, 1'b0};
        tab[3] = '{1'b1, 1'b0, 1'b0, 1'b0};
        tab[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        tab[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tab[6] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tab[7] = '{1'b1, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        do_reset();
        // Early triggers ignored, trigger at sample 5 captures 1..16
        got.delete();
        for (int i = 0; i < 8; i++) begin
            chk("tab_armed", armed, tab[i].armed);
            chk("tab_busy", busy, tab[i].busy);
            tick(tab[i].en, tab[i].trig, 1'b1);
        end
        drain(0);
        chk_window("early_trig", 1, 5, 16);
        // Plain capture around sample 20
        do_reset(); got.delete();
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        drain(0);
        chk_window("basic", 16, 20, 31);
        // Back-pressure with toggling and random stalls
        do_reset(); got.delete();
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        drain(2);
        chk_window("stall", 16, 20, 31);
        // en gap in POST between samples 24 and 25
        do_reset(); got.delete();
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
        drain(0);
        chk_window("en_gap", 16, 20, 31);
        // Reset after 5 accepted words, then re-arm from scratch
        do_reset(); got.delete();
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        for (int n = 0; n < 100 && m_words < 5; n++) tick(1'b1, 1'b0, 1'b1);
        chk("words_before_rst", m_words, 5);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_armed", armed, 0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1);
        chk("rearm_busy", busy, 1);
        got.delete();
        drain(0);
        chk_window("after_rst", 0, 4, 15);
        // Trigger and microphone churn during readout, then re-arm
        do_reset(); got.delete();
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        drain(1);
        chk_window("churn", 16, 20, 31);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1);
        chk("rearm_armed", armed, 1);
        tick(1'b1, 1'b1, 1'b1);
        drain(0);
        // Fully random traffic
        for (int k = 0; k < 1500; k++)
            tick(1'($urandom % 4 != 0), 1'($urandom % 8 == 0), 1'($urandom % 3 != 0));
        drain(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
